// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and emits one quotient bit into the dividend's LSB.
module div_step #(
  parameter int N_REG = 32
) (
  input  logic [N_REG-1:0] rem,
  input  logic [N_REG-1:0] dvd,
  input  logic [N_REG-1:0] dsr,
  output logic [N_REG-1:0] rem_nxt,
  output logic [N_REG-1:0] dvd_nxt
);

  logic [N_REG:0] partial;
  logic           ge;

  // The remainder stays below the divisor, so the difference always fits in N_REG bits.
  always_comb begin
    partial = {rem, dvd[N_REG-1]};
    ge      = (partial >= {1'b0, dsr});
    rem_nxt = ge ? (partial[N_REG-1:0] - dsr) : partial[N_REG-1:0];
    dvd_nxt = {dvd[N_REG-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: one restoring step per clock on operand
// magnitudes, sign fix-up applied when results are presented in DONE.
module div_unit #(
  parameter int N_REG      = 32,
  parameter int DIV_CYCLES = div_unit_pkg::DIV_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_divstart,
  input  logic             i_divsigned,
  input  logic [N_REG-1:0] i_dividend,
  input  logic [N_REG-1:0] i_divisor,
  input  logic             i_annul,
  output logic             o_div_ready,
  output logic             o_div_done,
  output logic [N_REG-1:0] o_quotient,
  output logic [N_REG-1:0] o_remainder
);
  import div_unit_pkg::*;

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [N_REG-1:0] dvd_q, rem_q, dsr_q;
  logic [N_REG-1:0] dvd_nxt, rem_nxt;
  logic             neg_quo, neg_rem;
  logic             accept;

  function automatic logic [N_REG-1:0] magnitude(input logic [N_REG-1:0] v, input logic sgn);
    return (sgn && v[N_REG-1]) ? (-v) : v;
  endfunction

  function automatic logic [N_REG-1:0] neg_if(input logic [N_REG-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  assign accept = (state == IDLE) && i_divstart && !i_annul;

  div_step #(.N_REG(N_REG)) u_step (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .dsr     (dsr_q),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // DONE always shows its result for at least one cycle before start may release it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (i_divisor == '0) ? BYZERO : ON;
      BYZERO:  next_state = i_annul ? IDLE : DONE;
      ON: begin
        if (i_annul)                                next_state = IDLE;
        else if (cnt == CNT_W'(DIV_CYCLES - 1))     next_state = DONE;
      end
      DONE:    if (i_annul || (o_div_done && !i_divstart)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_div_ready = (state == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      o_div_done  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      if (state == IDLE)    cnt <= '0;
      else if (state == ON) cnt <= cnt + 1'b1;

      if (state == DONE && next_state == DONE) begin
        o_div_done  <= 1'b1;
        o_quotient  <= neg_if(dvd_q, neg_quo);
        o_remainder <= neg_if(rem_q, neg_rem);
      end else begin
        o_div_done  <= 1'b0;
        o_quotient  <= '0;
        o_remainder <= '0;
      end
    end
  end

  // Datapath: dvd_q shifts out dividend bits and collects quotient bits.
  always_ff @(posedge i_clk) begin
    case (state)
      IDLE: if (accept) begin
        dvd_q   <= magnitude(i_dividend, i_divsigned);
        dsr_q   <= magnitude(i_divisor, i_divsigned);
        rem_q   <= '0;
        neg_quo <= i_divsigned && (i_dividend[N_REG-1] ^ i_divisor[N_REG-1]);
        neg_rem <= i_divsigned && i_dividend[N_REG-1];
      end
      BYZERO: begin
        dvd_q   <= '0;
        rem_q   <= '0;
        neg_quo <= 1'b0;
        neg_rem <= 1'b0;
      end
      ON: begin
        dvd_q <= dvd_nxt;
        rem_q <= rem_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed fix-up, divide-by-zero,
// annul and asynchronous reset behaviour.
module tb_div_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_divstart;
  logic        i_divsigned;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_annul;
  logic        o_div_ready;
  logic        o_div_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;

  int total = 0;
  int bad   = 0;

  div_unit #(.N_REG(32), .DIV_CYCLES(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_divstart  (i_divstart),
    .i_divsigned (i_divsigned),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_annul     (i_annul),
    .o_div_ready (o_div_ready),
    .o_div_done  (o_div_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Start at edge E0, scramble operands afterwards, return edge count to first done.
  task automatic launch(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge i_clk);
    i_divsigned = sg;
    i_dividend  = a;
    i_divisor   = b;
    i_divstart  = 1'b1;
    @(posedge i_clk);
    #1;
    i_dividend = ~a;
    i_divisor  = b ^ 32'h5A5A_0001;
    chk({tag, "_busy"}, {31'd0, o_div_ready}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge i_clk);
      #1;
      if (o_div_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] eq, input logic [31:0] er);
    int lat;
    launch(tag, sg, a, b, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quo"}, o_quotient, eq);
    chk({tag, "_rem"}, o_remainder, er);
    @(posedge i_clk);
    #1;
    chk({tag, "_hold_done"}, {31'd0, o_div_done}, 32'd1);
    chk({tag, "_hold_quo"}, o_quotient, eq);
    i_divstart = 1'b0;
    @(posedge i_clk);
    #1;
    chk({tag, "_drop_done"}, {31'd0, o_div_done}, 32'd0);
    chk({tag, "_drop_quo"}, o_quotient, 32'd0);
    chk({tag, "_drop_rem"}, o_remainder, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_div_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    i_rst_n     = 1'b0;
    i_divstart  = 1'b0;
    i_divsigned = 1'b0;
    i_dividend  = '0;
    i_divisor   = '0;
    i_annul     = 1'b0;
    #1;
    chk("rst_ready", {31'd0, o_div_ready}, 32'd1);
    chk("rst_done", {31'd0, o_div_done}, 32'd0);
    chk("rst_quo", o_quotient, 32'd0);
    chk("rst_rem", o_remainder, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    run_div("u100_7",   1'b0, 32'd100,       32'd7,        33, 32'd14,        32'd2);
    run_div("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("s_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_div("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2,        33, 32'h7FFF_FFFC, 32'd1);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("byzero",   1'b0, 32'h0000_1234, 32'd0,        2,  32'd0,         32'd0);

    // Annul mid-division, start already released
    @(negedge i_clk);
    i_divsigned = 1'b0;
    i_dividend  = 32'hFFFF_FFFF;
    i_divisor   = 32'd1;
    i_divstart  = 1'b1;
    @(posedge i_clk);
    #1;
    i_divstart = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("annul_busy", {31'd0, o_div_ready}, 32'd0);
    i_annul = 1'b1;
    @(posedge i_clk);
    #1;
    i_annul = 1'b0;
    chk("annul_ready", {31'd0, o_div_ready}, 32'd1);
    chk("annul_done", {31'd0, o_div_done}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_div_done) seen++;
    end
    chk("annul_no_done", 32'(seen), 32'd0);
    run_div("restart", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);

    // Annul while holding a finished result
    launch("annul_done", 1'b0, 32'd50, 32'd5, lat);
    chk("annul_done_quo", o_quotient, 32'd10);
    i_annul = 1'b1;
    @(posedge i_clk);
    #1;
    i_annul    = 1'b0;
    i_divstart = 1'b0;
    chk("annul_done_flag", {31'd0, o_div_done}, 32'd0);
    chk("annul_done_clr", o_quotient, 32'd0);
    chk("annul_done_ready", {31'd0, o_div_ready}, 32'd1);

    // Reset asserted mid-division
    @(negedge i_clk);
    i_dividend = 32'd1000;
    i_divisor  = 32'd10;
    i_divstart = 1'b1;
    @(posedge i_clk);
    #1;
    i_divstart = 1'b0;
    repeat (15) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rst_on_ready", {31'd0, o_div_ready}, 32'd1);
    chk("rst_on_done", {31'd0, o_div_done}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_div("after_rst", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Reset asserted while a result is displayed
    launch("rst_done", 1'b0, 32'd21, 32'd4, lat);
    chk("rst_done_pre", o_quotient, 32'd5);
    i_rst_n = 1'b0;
    #1;
    chk("rst_done_flag", {31'd0, o_div_done}, 32'd0);
    chk("rst_done_quo", o_quotient, 32'd0);
    chk("rst_done_rem", o_remainder, 32'd0);
    chk("rst_done_ready", {31'd0, o_div_ready}, 32'd1);
    i_divstart = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
